// File: rtl/hidden_delta_engine_if.sv
// rtl/hidden_delta_engine_if.sv - request/operand/result bundle for the hidden-layer delta engine
interface hidden_delta_engine_if #(
    parameter int N_HID = 5,
    parameter int N_OUT = 3,
    parameter int W     = 10
);
    logic                     start;
    logic                     mode;
    logic [N_OUT*W-1:0]       delta1_mag;
    logic [N_OUT-1:0]         delta1_sign;
    logic [N_OUT*N_HID*W-1:0] weight;
    logic [N_HID*W-1:0]       out0;
    logic                     busy;
    logic                     done;
    logic [N_HID*W-1:0]       delta0;
    logic [N_HID-1:0]         sign0;
    logic [N_HID-1:0]         sat;

    modport master (
        output start, mode, delta1_mag, delta1_sign, weight, out0,
        input  busy, done, delta0, sign0, sat
    );

    modport slave (
        input  start, mode, delta1_mag, delta1_sign, weight, out0,
        output busy, done, delta0, sign0, sat
    );
endinterface

// File: rtl/hidden_delta_engine.sv
// rtl/hidden_delta_engine.sv - sequential hidden-layer backprop delta engine, one shared MAC
module hidden_delta_engine #(
    parameter int N_HID = 5,
    parameter int N_OUT = 3,
    parameter int W     = 10,
    parameter int FRAC  = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    hidden_delta_engine_if.slave bus
);
    // Accumulator holds N_OUT signed products of W-bit magnitude x W-bit weight.
    localparam int AW = 2*W + 1 + $clog2(N_OUT);
    localparam int PW = 2*W + 1;
    // Derivative needs room for out0*(ONE-out0) when out0 exceeds ONE.
    localparam int DW = 2*W + 4;
    localparam int RW = AW + DW;
    localparam int JW = (N_HID > 1) ? $clog2(N_HID) : 1;
    localparam int KW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    localparam logic signed [DW-1:0] ONE_D    = DW'(2**FRAC);
    localparam logic        [RW-1:0] MAX_MAG  = RW'(2**W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        SCALE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [JW-1:0]          j_q, j_d;
    logic [KW-1:0]          k_q, k_d;
    logic signed [AW-1:0]   acc_q, acc_d;
    logic [N_HID*W-1:0]     delta0_q, delta0_d;
    logic [N_HID-1:0]       sign0_q, sign0_d;
    logic [N_HID-1:0]       sat_q, sat_d;

    // Datapath signals
    logic [W-1:0]           mag_k;
    logic signed [W-1:0]    w_kj;
    logic signed [PW-1:0]   mag_s;
    logic signed [PW-1:0]   w_s;
    logic signed [PW-1:0]   prod;
    logic signed [PW-1:0]   term;
    logic [W-1:0]           out_j;
    logic signed [DW-1:0]   o_s;
    logic signed [DW-1:0]   d_prod;
    logic signed [DW-1:0]   d_val;
    logic signed [RW-1:0]   r_full;
    logic signed [RW-1:0]   r_sh;
    logic [RW-1:0]          r_abs;
    logic                   res_neg;
    logic                   res_sat;
    logic [W-1:0]           res_mag;

    // Operand selection, signed MAC term, derivative and scaled result for the current (j,k)
    always_comb begin
        mag_k  = bus.delta1_mag[int'(k_q)*W +: W];
        w_kj   = bus.weight[(int'(k_q)*N_HID + int'(j_q))*W +: W];
        mag_s  = PW'(mag_k);
        w_s    = PW'(w_kj);
        prod   = mag_s * w_s;
        term   = bus.delta1_sign[k_q] ? -prod : prod;

        out_j  = bus.out0[int'(j_q)*W +: W];
        o_s    = DW'(out_j);
        d_prod = o_s * (ONE_D - o_s);
        d_val  = bus.mode ? ONE_D : (d_prod >>> FRAC);

        r_full  = RW'(acc_q) * RW'(d_val);
        r_sh    = r_full >>> (2*FRAC);
        res_neg = r_sh[RW-1];
        r_abs   = res_neg ? RW'(-r_sh) : RW'(r_sh);
        res_sat = (r_abs > MAX_MAG);
        res_mag = res_sat ? {W{1'b1}} : r_abs[W-1:0];
    end

    // Next-state and register updates for the IDLE/MAC/SCALE/DONE sequencer
    always_comb begin
        state_d  = state_q;
        j_d      = j_q;
        k_d      = k_q;
        acc_d    = acc_q;
        delta0_d = delta0_q;
        sign0_d  = sign0_q;
        sat_d    = sat_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = MAC;
                    j_d     = '0;
                    k_d     = '0;
                    acc_d   = '0;
                end
            end
            MAC: begin
                acc_d = acc_q + AW'(term);
                if (k_q == KW'(N_OUT-1)) begin
                    state_d = SCALE;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            SCALE: begin
                for (int i = 0; i < N_HID; i++) begin
                    if (JW'(i) == j_q) begin
                        delta0_d[i*W +: W] = res_mag;
                        sign0_d[i]         = res_neg;
                        sat_d[i]           = res_sat;
                    end
                end
                if (j_q == JW'(N_HID-1)) begin
                    state_d = DONE;
                end else begin
                    state_d = MAC;
                    j_d     = j_q + JW'(1);
                    k_d     = '0;
                    acc_d   = '0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, indices, accumulator and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            j_q      <= '0;
            k_q      <= '0;
            acc_q    <= '0;
            delta0_q <= '0;
            sign0_q  <= '0;
            sat_q    <= '0;
        end else begin
            state_q  <= state_d;
            j_q      <= j_d;
            k_q      <= k_d;
            acc_q    <= acc_d;
            delta0_q <= delta0_d;
            sign0_q  <= sign0_d;
            sat_q    <= sat_d;
        end
    end

    assign bus.busy   = (state_q != IDLE);
    assign bus.done   = (state_q == DONE);
    assign bus.delta0 = delta0_q;
    assign bus.sign0  = sign0_q;
    assign bus.sat    = sat_q;
endmodule

// File: tb/tb_hidden_delta_engine.sv
// tb/tb_hidden_delta_engine.sv - scoreboard bench for hidden_delta_engine
module tb_hidden_delta_engine;
    localparam int N_HID = 5;
    localparam int N_OUT = 3;
    localparam int W     = 10;
    localparam int FRAC  = 6;
    localparam int LAT   = N_HID*(N_OUT+1) + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hidden_delta_engine_if #(.N_HID(N_HID), .N_OUT(N_OUT), .W(W)) bus();

    hidden_delta_engine #(.N_HID(N_HID), .N_OUT(N_OUT), .W(W), .FRAC(FRAC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [N_HID*W-1:0] d;
        logic [N_HID-1:0]   s;
        logic [N_HID-1:0]   t;
    } exp_t;

    exp_t sb[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    int   m_mag [N_OUT];
    bit   m_sgn [N_OUT];
    int   m_w   [N_OUT][N_HID];
    int   m_o   [N_HID];
    bit   m_mode;

    function automatic exp_t model();
        exp_t e;
        for (int j = 0; j < N_HID; j++) begin
            longint acc = 0;
            longint dv;
            longint r;
            longint a;
            for (int k = 0; k < N_OUT; k++) begin
                longint t = longint'(m_mag[k]) * longint'(m_w[k][j]);
                acc += m_sgn[k] ? -t : t;
            end
            if (m_mode) dv = 64;
            else        dv = (longint'(m_o[j]) * (64 - longint'(m_o[j]))) >>> 6;
            r = (acc * dv) >>> 12;
            e.s[j] = (r < 0);
            a = (r < 0) ? -r : r;
            if (a > 1023) begin
                e.t[j] = 1'b1;
                a = 1023;
            end else begin
                e.t[j] = 1'b0;
            end
            e.d[j*W +: W] = W'(a);
        end
        return e;
    endfunction

    task automatic apply_inputs();
        bus.mode = m_mode;
        for (int k = 0; k < N_OUT; k++) begin
            bus.delta1_mag[k*W +: W] = W'(m_mag[k]);
            bus.delta1_sign[k]       = m_sgn[k];
            for (int j = 0; j < N_HID; j++)
                bus.weight[(k*N_HID+j)*W +: W] = W'(m_w[k][j]);
        end
        for (int j = 0; j < N_HID; j++) bus.out0[j*W +: W] = W'(m_o[j]);
    endtask

    task automatic set_base(input bit mode);
        m_mode = mode;
        for (int k = 0; k < N_OUT; k++) begin
            m_mag[k] = 64;
            m_sgn[k] = 1'b0;
            for (int j = 0; j < N_HID; j++) m_w[k][j] = 64;
        end
        for (int j = 0; j < N_HID; j++) m_o[j] = 32;
    endtask

    task automatic launch(input bit expect_done);
        @(negedge clk);
        apply_inputs();
        bus.start = 1'b1;
        if (expect_done) sb.push_back(model());
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Returns the cycle number (start cycle = 0) in which done is seen, or -1 on timeout
    task automatic wait_done(output int cyc);
        int n = 0;
        while (bus.done !== 1'b1 && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        cyc = (bus.done === 1'b1) ? n + 1 : -1;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every done pulse pops the oldest expectation and compares all neurons
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_done: done=%b with no run pending (required none)", bus.done);
            end else begin
                e = sb.pop_front();
                total_cnt++;
                if (bus.delta0 !== e.d) $display("FAIL delta0: got %h required %h", bus.delta0, e.d);
                else pass_cnt++;
                total_cnt++;
                if (bus.sign0 !== e.s) $display("FAIL sign0: got %b required %b", bus.sign0, e.s);
                else pass_cnt++;
                total_cnt++;
                if (bus.sat !== e.t) $display("FAIL sat: got %b required %b", bus.sat, e.t);
                else pass_cnt++;
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total_cnt++;
        if ({bus.busy, bus.done} !== 2'b00) $display("FAIL reset_ctl: busy/done=%b required 00", {bus.busy, bus.done});
        else pass_cnt++;
        total_cnt++;
        if (bus.delta0 !== '0) $display("FAIL reset_delta0: got %h required 0", bus.delta0);
        else pass_cnt++;
        total_cnt++;
        if ({bus.sign0, bus.sat} !== '0) $display("FAIL reset_flags: got %b required 0", {bus.sign0, bus.sat});
        else pass_cnt++;
        rst_n = 1'b1;
    endtask

    task automatic test_linear();
        int cyc;
        set_base(1'b1);
        launch(1'b1);
        total_cnt++;
        if (bus.busy !== 1'b1) $display("FAIL linear_busy: got %b required 1", bus.busy);
        else pass_cnt++;
        wait_done(cyc);
        total_cnt++;
        if (cyc != LAT) $display("FAIL linear_latency: got %0d required %0d", cyc, LAT);
        else pass_cnt++;
        total_cnt++;
        if (bus.delta0[W-1:0] !== W'(192)) $display("FAIL linear_value: got %0d required 192", bus.delta0[W-1:0]);
        else pass_cnt++;
    endtask

    task automatic test_sigmoid();
        int cyc;
        set_base(1'b0);
        launch(1'b1);
        wait_done(cyc);
        total_cnt++;
        if (bus.delta0[4*W +: W] !== W'(48)) $display("FAIL sigmoid_value: got %0d required 48", bus.delta0[4*W +: W]);
        else pass_cnt++;
    endtask

    task automatic test_sign();
        int cyc;
        set_base(1'b1);
        m_sgn[1] = 1'b1;
        launch(1'b1);
        wait_done(cyc);
        total_cnt++;
        if ({bus.sign0[0], bus.delta0[W-1:0]} !== {1'b0, W'(64)})
            $display("FAIL sign_010: got s=%b m=%0d required s=0 m=64", bus.sign0[0], bus.delta0[W-1:0]);
        else pass_cnt++;
        m_sgn[2] = 1'b1;
        launch(1'b1);
        wait_done(cyc);
        total_cnt++;
        if ({bus.sign0[0], bus.delta0[W-1:0]} !== {1'b1, W'(64)})
            $display("FAIL sign_110: got s=%b m=%0d required s=1 m=64", bus.sign0[0], bus.delta0[W-1:0]);
        else pass_cnt++;
        m_sgn[2] = 1'b0;
        m_mag[1] = 128;
        launch(1'b1);
        wait_done(cyc);
        total_cnt++;
        if ({bus.sign0, bus.delta0} !== '0)
            $display("FAIL sign_zero: got s=%b m=%h required all zero", bus.sign0, bus.delta0);
        else pass_cnt++;
    endtask

    task automatic test_saturation();
        int cyc;
        set_base(1'b1);
        for (int k = 0; k < N_OUT; k++) begin
            m_mag[k] = 1023;
            for (int j = 0; j < N_HID; j++) m_w[k][j] = 511;
        end
        launch(1'b1);
        wait_done(cyc);
        total_cnt++;
        if (bus.sat !== 5'h1f) $display("FAIL sat_high: got %b required 11111", bus.sat);
        else pass_cnt++;
        for (int k = 0; k < N_OUT; k++)
            for (int j = 0; j < N_HID; j++) m_w[k][j] = 1;
        launch(1'b1);
        wait_done(cyc);
        total_cnt++;
        if ({bus.sat, bus.delta0[2*W +: W]} !== {5'h00, W'(47)})
            $display("FAIL sat_low: got sat=%b m=%0d required sat=0 m=47", bus.sat, bus.delta0[2*W +: W]);
        else pass_cnt++;
    endtask

    task automatic test_zero_deriv();
        int cyc;
        set_base(1'b0);
        m_o[2] = 0;
        m_o[3] = 64;
        launch(1'b1);
        wait_done(cyc);
        total_cnt++;
        if (bus.delta0[2*W +: 2*W] !== '0) $display("FAIL zero_deriv: got %h required 0", bus.delta0[2*W +: 2*W]);
        else pass_cnt++;
    endtask

    task automatic test_start_while_busy();
        int dones = 0;
        int first = -1;
        set_base(1'b1);
        launch(1'b1);
        repeat (5) @(posedge clk);
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) begin
                dones++;
                if (first < 0) first = i;
            end
        end
        total_cnt++;
        if (dones != 1) $display("FAIL busy_start_dones: got %0d required 1", dones);
        else pass_cnt++;
        total_cnt++;
        if (bus.busy !== 1'b0) $display("FAIL busy_start_idle: busy=%b required 0", bus.busy);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int dones = 0;
        set_base(1'b1);
        launch(1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({bus.busy, bus.done, bus.delta0, bus.sign0, bus.sat} !== '0)
            $display("FAIL mid_reset_clear: busy=%b done=%b d=%h s=%b t=%b required all 0",
                     bus.busy, bus.done, bus.delta0, bus.sign0, bus.sat);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) dones++;
        end
        total_cnt++;
        if (dones != 0) $display("FAIL mid_reset_done: got %0d pulses required 0", dones);
        else pass_cnt++;
    endtask

    task automatic test_after_reset();
        int cyc;
        set_base(1'b1);
        m_w[0][1] = -200;
        m_sgn[0] = 1'b1;
        launch(1'b1);
        wait_done(cyc);
        total_cnt++;
        if (cyc != LAT) $display("FAIL after_reset_latency: got %0d required %0d", cyc, LAT);
        else pass_cnt++;
    endtask

    initial begin
        bus.start       = 1'b0;
        bus.mode        = 1'b0;
        bus.delta1_mag  = '0;
        bus.delta1_sign = '0;
        bus.weight      = '0;
        bus.out0        = '0;
        test_reset();
        test_linear();
        test_sigmoid();
        test_sign();
        test_saturation();
        test_zero_deriv();
        test_start_while_busy();
        test_reset_mid();
        test_after_reset();
        repeat (3) @(posedge clk);
        total_cnt++;
        if (sb.size() != 0) $display("FAIL scoreboard_drain: %0d pending required 0", sb.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/hidden_delta_engine.md
# hidden_delta_engine

Sequential, parametrised hidden-layer backpropagation delta engine. For each hidden neuron j it computes delta0[j] = f'(out0[j]) * Σk delta1[k]*w[k][j], using a single time-shared multiplier. Results use the sign-magnitude delta format, so the outputs feed the next layer's engine directly. It sits between the output-layer delta stage and the weight-update stage of the training datapath.

## Interface
Parameters:
- N_HID, 5, number of hidden neurons (≥1)
- N_OUT, 3, number of next-layer neurons (≥1)
- W, 10, data width
- FRAC, 6, fractional bits; ONE = 2^FRAC

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  request; accepted only in IDLE
- mode  in  1  0 = sigmoid derivative, 1 = linear (derivative = ONE)
- delta1_mag  in  N_OUT*W  unsigned magnitudes; element k at [k*W +: W]
- delta1_sign  in  N_OUT  1 = negative
- weight  in  N_OUT*N_HID*W  two's-complement; w[k][j] at [(k*N_HID+j)*W +: W]
- out0  in  N_HID*W  unsigned activations, Q.FRAC
- busy  out  1  high while computing
- done  out  1  one-cycle completion pulse
- delta0  out  N_HID*W  result magnitudes
- sign0  out  N_HID  result signs
- sat  out  N_HID  magnitude-saturated flag per neuron

## Operation
- All inputs except start must be held stable from the accepting cycle until done. The block does not capture them.
- FSM states and transitions:
  - IDLE: start=1 → MAC, with j=0, k=0, acc=0.
  - MAC: acc += s_k*delta1_mag[k]*w[k][j], where s_k = −1 if delta1_sign[k] is set. k increments each cycle. After k = N_OUT−1 → SCALE.
  - SCALE: writes neuron j. If j = N_HID−1 → DONE; otherwise j++, k=0, acc=0 → MAC.
  - DONE: done=1 → IDLE.
- Accumulator: signed, 2W+1+clog2(N_OUT) bits; no overflow is possible. Values carry 2·FRAC fractional bits.
- Derivative D:
  - mode 0: D = (out0[j]*(ONE−out0[j])) >>> FRAC, computed signed. An input with out0 > ONE yields a negative D, which is used as-is.
  - mode 1: D = ONE.
  - mode is sampled each SCALE cycle.
- Result: r = (acc*D) >>> 2·FRAC, arithmetic shift.
  - sign0[j] = (r < 0).
  - Magnitude = |r|, saturated to 2^W−1. sat[j] is set when saturation occurs.
  - r = 0 gives sign0 = 0.
- delta0, sign0 and sat for neuron j update only in its SCALE cycle. Neurons not yet rewritten keep their previous values.
- start is ignored in MAC, SCALE and DONE.

## Timing
- Reset (asynchronous, any state): state = IDLE, j=k=acc=0, busy=0, done=0, delta0=0, sign0=0, sat=0.
- If reset is asserted mid-operation, the run is abandoned and no done pulse is issued. After rst_n deasserts, the first edge is treated as IDLE.
- start is sampled at edge t.
  - busy=1 from t+1 through the DONE cycle inclusive.
  - done=1 for exactly cycle t + N_HID*(N_OUT+1) + 1; this is cycle 21 for the defaults.
- Neuron j's outputs are valid from edge t + (j+1)*(N_OUT+1) + 1.
- A new start is accepted the cycle after done, while the block is in IDLE again. There is no back-to-back acceptance during DONE.
- One multiply per MAC cycle; one derivative multiply and one scale multiply per SCALE cycle. All are registered and there is no internal pipelining.

## Test plan
- Linear pass: mode=1, all w=64, all delta1_mag=64 with sign 0, out0=any. Required: every delta0=192, sign0=0, sat=0, and done at exactly start+21.
- Sigmoid derivative: mode=0, out0=32 for all neurons, same weights and deltas as above. Required: D=16 and every delta0=48, sign0=0.
- Sign handling, mode=1:
  - delta1_sign=3'b010 → delta0=64, sign0=0.
  - delta1_sign=3'b110 → delta0=64, sign0=1.
  - delta1_sign=3'b010 with delta1_mag[1]=128 → r=0, so delta0=0, sign0=0.
- Saturation: mode=1, all w=511, all delta1_mag=1023, signs 0. Required: delta0=1023 and sat=1 for all neurons.
  - Repeat with all w=1: delta0=47 and sat=0.
- Zero derivative: mode=0, out0[2]=0 and out0[3]=64, others 32, with the first test's stimulus. Required: delta0[2]=delta0[3]=0 with sign 0; the others are 48.
- Control:
  - A start pulse while busy is ignored and done is still issued once.
  - rst_n pulsed low mid-MAC clears all outputs and busy immediately, and no done pulse follows.
  - A fresh start after reset completes normally in 21 cycles.
